// File: rtl/grant_burst_mux.sv
// grant_burst_mux
//   Sits behind a round-robin arbiter and moves one burst of up to BURST_LEN
//   beats from the granted requester to a single shared resource. The owner is
//   captured only while idle, so the arbiter may rotate its grant freely while
//   a burst is in flight.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   Req             per-requester request level (same lines the arbiter sees)
//   Grant           one-hot grant from the arbiter
//   Data_in         packed requester beats, slice i = [i*DATA_WIDTH +: DATA_WIDTH]
//   Data_valid      requester i has a beat on its slice
//   Data_ack        combinational pop strobe to the owning requester
//   Out_data        registered beat towards the shared resource
//   Out_valid       Out_data holds a beat
//   Out_ready       shared resource takes the beat
//   Owner           registered one-hot owner of the current burst, 0 when idle
//   Busy            high whenever the block is not idle
//   Done            one-cycle pulse to the owner when its burst finishes
//   Grant_err       one-cycle pulse when an idle-time grant is not one-hot
module grant_burst_mux #(
  parameter int INPUT_WIDTH = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int BURST_LEN   = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [INPUT_WIDTH-1:0]            Req,
  input  logic [INPUT_WIDTH-1:0]            Grant,
  input  logic [INPUT_WIDTH*DATA_WIDTH-1:0] Data_in,
  input  logic [INPUT_WIDTH-1:0]            Data_valid,
  output logic [INPUT_WIDTH-1:0]            Data_ack,
  output logic [DATA_WIDTH-1:0]             Out_data,
  output logic                              Out_valid,
  input  logic                              Out_ready,
  output logic [INPUT_WIDTH-1:0]            Owner,
  output logic                              Busy,
  output logic [INPUT_WIDTH-1:0]            Done,
  output logic                              Grant_err
);

  localparam int CW = $clog2(BURST_LEN + 1);
  localparam logic [CW-1:0] BL    = CW'(BURST_LEN);
  localparam logic [CW-1:0] CNT_1 = CW'(1);
  localparam logic [INPUT_WIDTH-1:0] ONE_W = INPUT_WIDTH'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_XFER  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]             state_q, state_d;
  logic [INPUT_WIDTH-1:0] owner_q, owner_d;
  logic [CW-1:0]          loaded_q, loaded_d;
  logic [CW-1:0]          sent_q, sent_d;
  logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
  logic                   out_valid_q, out_valid_d;
  logic [INPUT_WIDTH-1:0] done_q, done_d;
  logic                   gerr_q, gerr_d;

  logic [DATA_WIDTH-1:0]  sel_data;
  logic                   grant_onehot;
  logic                   grant_multi;
  logic                   owner_req;
  logic                   owner_dv;
  logic                   can_load;
  logic                   accept;

  // Owner is one-hot, so an OR of the masked slices selects its beat.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < INPUT_WIDTH; i++) begin
      if (owner_q[i]) sel_data = sel_data | Data_in[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign grant_onehot = (Grant != '0) && ((Grant & (Grant - ONE_W)) == '0);
  assign grant_multi  = (Grant != '0) && !grant_onehot;
  assign owner_req    = |(Req & owner_q);
  assign owner_dv     = |(Data_valid & owner_q);
  assign accept       = out_valid_q && Out_ready;

  // A new beat may enter the output register when it is empty or being
  // emptied this very cycle, which gives one beat per cycle at full rate.
  assign can_load = (state_q == S_XFER) && owner_dv && owner_req &&
                    (!out_valid_q || Out_ready) && (loaded_q < BL);

  assign Data_ack = can_load ? owner_q : '0;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    loaded_d    = loaded_q;
    sent_d      = sent_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    done_d      = '0;
    gerr_d      = 1'b0;

    if (can_load) begin
      out_data_d  = sel_data;
      out_valid_d = 1'b1;
      loaded_d    = loaded_q + CNT_1;
    end else if (accept) begin
      out_valid_d = 1'b0;
    end

    if (accept && (sent_q != BL)) sent_d = sent_q + CNT_1;

    case (state_q)
      S_IDLE: begin
        if (grant_onehot && ((Req & Grant) != '0)) begin
          owner_d  = Grant;
          loaded_d = '0;
          sent_d   = '0;
          state_d  = S_XFER;
        end else if (grant_multi) begin
          gerr_d = 1'b1;
        end
      end
      S_XFER: begin
        // Leaves after the final load commits, or immediately when the owner
        // withdraws its request (no load can happen in that cycle).
        if (!owner_req || (loaded_d == BL)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (!out_valid_q || Out_ready) state_d = S_DONE;
      end
      S_DONE: begin
        done_d  = owner_q;
        owner_d = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      owner_q     <= '0;
      loaded_q    <= '0;
      sent_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= '0;
      gerr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      loaded_q    <= loaded_d;
      sent_q      <= sent_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      gerr_q      <= gerr_d;
    end
  end

  assign Out_data  = out_data_q;
  assign Out_valid = out_valid_q;
  assign Owner     = owner_q;
  assign Busy      = (state_q != S_IDLE);
  assign Done      = done_q;
  assign Grant_err = gerr_q;

endmodule
